// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the sequenced ALU control unit.
//  - aluop class encodings from the main control FSM
//  - 3-bit alu_ctr codes driven to the ALU
//  - FSM state enum and the position of the iterative-op flag in funct
package alu_ctrl_pkg;

   localparam int unsigned OPW  = 3;
   localparam int unsigned CTRW = 3;

   // aluop classes
   localparam logic [OPW-1:0] ALUOP_RTYPE = 3'b000;
   localparam logic [OPW-1:0] ALUOP_OR    = 3'b001;
   localparam logic [OPW-1:0] ALUOP_AND   = 3'b010;
   localparam logic [OPW-1:0] ALUOP_NOR   = 3'b011;
   localparam logic [OPW-1:0] ALUOP_XOR   = 3'b100;
   localparam logic [OPW-1:0] ALUOP_ADD   = 3'b101;
   localparam logic [OPW-1:0] ALUOP_SUB   = 3'b110;
   localparam logic [OPW-1:0] ALUOP_SUB2  = 3'b111;

   // alu_ctr codes
   localparam logic [CTRW-1:0] CTR_AND = 3'b000;
   localparam logic [CTRW-1:0] CTR_OR  = 3'b001;
   localparam logic [CTRW-1:0] CTR_ADD = 3'b010;
   localparam logic [CTRW-1:0] CTR_XOR = 3'b100;
   localparam logic [CTRW-1:0] CTR_NOR = 3'b101;
   localparam logic [CTRW-1:0] CTR_SUB = 3'b110;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SINGLE = 2'd1,
      ITER   = 2'd2
   } state_t;

   // The iterative flag is the MSB of funct.
   function automatic int unsigned iter_bit_pos(input int unsigned fw);
      return fw - 1;
   endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Request/beat stream between main control, the ALU control sequencer and the datapath.
//  master: drives requests (in_valid/aluop/funct) and accepts beats (out_ready)
//  slave : the sequencer; returns in_ready and drives the control beat fields
interface alu_ctrl_if #(
   parameter int unsigned FW   = 4,
   parameter int unsigned CNTW = 5
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      aluop;
   logic [FW-1:0]   funct;
   logic            out_valid;
   logic            out_ready;
   logic [2:0]      alu_ctr;
   logic [CNTW-1:0] step;
   logic            first;
   logic            last;
   logic            busy;

   modport master (
      output in_valid, aluop, funct, out_ready,
      input  in_ready, out_valid, alu_ctr, step, first, last, busy
   );

   modport slave (
      input  in_valid, aluop, funct, out_ready,
      output in_ready, out_valid, alu_ctr, step, first, last, busy
   );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational aluop/funct[2:0] -> alu_ctr decode.
//  aluop     in  3  op class
//  funct_lo  in  3  low funct bits, used for R-type
//  alu_ctr_c out 3  decoded ALU control code
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
(
   input  logic [OPW-1:0]  aluop,
   input  logic [2:0]      funct_lo,
   output logic [CTRW-1:0] alu_ctr_c
);

   always_comb begin
      alu_ctr_c = CTR_AND;
      case (aluop)
         ALUOP_RTYPE: alu_ctr_c = funct_lo;
         ALUOP_OR:    alu_ctr_c = CTR_OR;
         ALUOP_AND:   alu_ctr_c = CTR_AND;
         ALUOP_NOR:   alu_ctr_c = CTR_NOR;
         ALUOP_XOR:   alu_ctr_c = CTR_XOR;
         ALUOP_ADD:   alu_ctr_c = CTR_ADD;
         ALUOP_SUB:   alu_ctr_c = CTR_SUB;
         ALUOP_SUB2:  alu_ctr_c = CTR_SUB;
         default:     alu_ctr_c = CTR_AND;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control sequencer. Accepts one request per handshake, emits
// a single control beat or ITER_CYCLES beats for iterative ops.
//  clk    in  clock, rising edge
//  rst_n  in  asynchronous active-low reset
//  flush  in  synchronous abort of the op in flight
//  bus    slave side of alu_ctrl_if (request in, control beat out)
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned FW          = 4,
   parameter int unsigned ITER_CYCLES = 32,
   parameter int unsigned CNTW        = ($clog2(ITER_CYCLES) == 0) ? 1 : $clog2(ITER_CYCLES)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   alu_ctrl_if.slave  bus
);

   localparam int unsigned    ITER_BIT  = iter_bit_pos(FW);
   localparam logic           ITER_EN   = 1'(ITER_CYCLES > 1);
   localparam logic [CNTW-1:0] LAST_STEP = CNTW'(ITER_CYCLES - 1);

   state_t          state_q, state_d;
   logic [CTRW-1:0] ctr_q, ctr_d;
   logic [CNTW-1:0] step_q, step_d;
   logic            first_q, first_d;
   logic            last_q, last_d;

   logic [CTRW-1:0] dec_ctr_c;
   logic            out_valid_c;
   logic            in_ready_c;
   logic            accept_c;
   logic            consume_c;
   logic            req_iter_c;

   // Decode sits on the request path so the output register holds the final code.
   alu_ctrl_decode u_decode (
      .aluop     (bus.aluop),
      .funct_lo  (bus.funct[2:0]),
      .alu_ctr_c (dec_ctr_c)
   );

   // With a single-beat iteration count an iterative op collapses to SINGLE.
   assign req_iter_c = ITER_EN & (bus.aluop == ALUOP_RTYPE) & bus.funct[ITER_BIT];
   assign accept_c   = bus.in_valid & in_ready_c;
   assign consume_c  = out_valid_c & bus.out_ready;

   // State and beat registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ctr_q   <= '0;
         step_q  <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         step_q  <= step_d;
         first_q <= first_d;
         last_q  <= last_d;
      end
   end

   // Next-state: flush > accept (new op) > consume (advance or retire)
   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      step_d  = step_q;
      first_d = first_q;
      last_d  = last_q;
      if (flush) begin
         state_d = IDLE;
         ctr_d   = '0;
         step_d  = '0;
         first_d = 1'b0;
         last_d  = 1'b0;
      end else if (accept_c) begin
         state_d = req_iter_c ? ITER : SINGLE;
         ctr_d   = dec_ctr_c;
         step_d  = '0;
         first_d = 1'b1;
         last_d  = !req_iter_c;
      end else if (consume_c) begin
         if (last_q) begin
            state_d = IDLE;
            ctr_d   = '0;
            step_d  = '0;
            first_d = 1'b0;
            last_d  = 1'b0;
         end else if (state_q == ITER) begin
            step_d  = step_q + CNTW'(1);
            first_d = 1'b0;
            last_d  = (step_q + CNTW'(1)) == LAST_STEP;
         end
      end
   end

   // Outputs: beat fields straight from registers; in_ready opens on the last consumed beat
   always_comb begin
      out_valid_c   = (state_q != IDLE);
      in_ready_c    = rst_n & !flush & (!out_valid_c | (bus.out_ready & last_q));
      bus.in_ready  = in_ready_c;
      bus.out_valid = out_valid_c;
      bus.busy      = out_valid_c;
      bus.alu_ctr   = ctr_q;
      bus.step      = step_q;
      bus.first     = first_q;
      bus.last      = last_q;
   end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq (FW=4, ITER_CYCLES=32).
module tb_alu_ctrl_seq;

   localparam int unsigned FW          = 4;
   localparam int unsigned ITER_CYCLES = 32;
   localparam int unsigned CNTW        = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected alu_ctr for aluop 0..7 with funct=4'b0110
   logic [2:0] exp_ctr [8] = '{3'b110, 3'b001, 3'b000, 3'b101, 3'b100, 3'b010, 3'b110, 3'b110};

   alu_ctrl_if #(.FW(FW), .CNTW(CNTW)) bus ();

   alu_ctrl_seq #(.FW(FW), .ITER_CYCLES(ITER_CYCLES), .CNTW(CNTW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {out_valid, alu_ctr, step, first, last, busy}
   function automatic logic [11:0] obs();
      return {bus.out_valid, bus.alu_ctr, bus.step, bus.first, bus.last, bus.busy};
   endfunction

   function automatic logic [11:0] beat(input logic [2:0] c, input logic [4:0] s,
                                        input logic f, input logic l);
      return {1'b1, c, s, f, l, 1'b1};
   endfunction

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.aluop     = 3'b000;
      bus.funct     = 4'b0000;
      bus.out_ready = 1'b0;
      #3;
      n_checks++;
      if (obs() !== 12'h000) begin
         n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs(), 12'h000);
      end
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
      end
      tick(); tick();
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready);
      end
      n_checks++;
      if (obs() !== 12'h000) begin
         n_fail++; $display("FAIL release_idle: got %h expected %h", obs(), 12'h000);
      end
   endtask

   task automatic test_single();
      bus.aluop     = 3'b011;
      bus.funct     = 4'b0000;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL single_in_ready: got %b expected 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      n_checks++;
      if (obs() !== beat(3'b101, 5'd0, 1'b1, 1'b1)) begin
         n_fail++; $display("FAIL single_beat: got %h expected %h", obs(), beat(3'b101, 5'd0, 1'b1, 1'b1));
      end
      tick();
      n_checks++;
      if (obs() !== 12'h000) begin
         n_fail++; $display("FAIL single_retire: got %h expected %h", obs(), 12'h000);
      end
   endtask

   task automatic test_back_to_back();
      bus.aluop     = 3'b000;
      bus.funct     = 4'b0110;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (obs() !== beat(exp_ctr[i], 5'd0, 1'b1, 1'b1)) begin
            n_fail++;
            $display("FAIL b2b_aluop%0d: got %h expected %h", i, obs(), beat(exp_ctr[i], 5'd0, 1'b1, 1'b1));
         end
         if (i < 7) bus.aluop = 3'(i + 1);
         else       bus.in_valid = 1'b0;
         #1;
         n_checks++;
         if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_in_ready%0d: got %b expected 1", i, bus.in_ready);
         end
         tick();
      end
      n_checks++;
      if (obs() !== 12'h000) begin
         n_fail++; $display("FAIL b2b_idle: got %h expected %h", obs(), 12'h000);
      end
   endtask

   task automatic test_iterative();
      bus.aluop     = 3'b000;
      bus.funct     = 4'b1010;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      tick();
      // Queue a follow-on request; it must wait for the last beat.
      bus.aluop = 3'b010;
      bus.funct = 4'b0000;
      for (int i = 0; i < 32; i++) begin
         #1;
         n_checks++;
         if (obs() !== beat(3'b010, 5'(i), i == 0, i == 31)) begin
            n_fail++;
            $display("FAIL iter_step%0d: got %h expected %h", i, obs(), beat(3'b010, 5'(i), i == 0, i == 31));
         end
         n_checks++;
         if (bus.in_ready !== 1'(i == 31)) begin
            n_fail++; $display("FAIL iter_in_ready%0d: got %b expected %b", i, bus.in_ready, i == 31);
         end
         tick();
      end
      bus.in_valid = 1'b0;
      n_checks++;
      if (obs() !== beat(3'b000, 5'd0, 1'b1, 1'b1)) begin
         n_fail++; $display("FAIL iter_followon: got %h expected %h", obs(), beat(3'b000, 5'd0, 1'b1, 1'b1));
      end
      tick();
      n_checks++;
      if (obs() !== 12'h000) begin
         n_fail++; $display("FAIL iter_idle: got %h expected %h", obs(), 12'h000);
      end
   endtask

   // Leaves an iterative op in flight at step 8.
   task automatic test_backpressure();
      bus.aluop     = 3'b000;
      bus.funct     = 4'b1010;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (7) tick();
      n_checks++;
      if (obs() !== beat(3'b010, 5'd7, 1'b0, 1'b0)) begin
         n_fail++; $display("FAIL bp_reach7: got %h expected %h", obs(), beat(3'b010, 5'd7, 1'b0, 1'b0));
      end
      bus.out_ready = 1'b0;
      bus.aluop     = 3'b111;
      bus.funct     = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (obs() !== beat(3'b010, 5'd7, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL bp_hold%0d: got %h expected %h", i, obs(), beat(3'b010, 5'd7, 1'b0, 1'b0));
         end
         n_checks++;
         if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready%0d: got %b expected 0", i, bus.in_ready);
         end
      end
      bus.out_ready = 1'b1;
      tick();
      n_checks++;
      if (obs() !== beat(3'b010, 5'd8, 1'b0, 1'b0)) begin
         n_fail++; $display("FAIL bp_resume: got %h expected %h", obs(), beat(3'b010, 5'd8, 1'b0, 1'b0));
      end
   endtask

   task automatic test_flush();
      repeat (4) tick();
      n_checks++;
      if (obs() !== beat(3'b010, 5'd12, 1'b0, 1'b0)) begin
         n_fail++; $display("FAIL flush_reach12: got %h expected %h", obs(), beat(3'b010, 5'd12, 1'b0, 1'b0));
      end
      flush         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.aluop     = 3'b101;
      bus.funct     = 4'b0000;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready);
      end
      tick();
      flush = 1'b0;
      #1;
      n_checks++;
      if (obs() !== 12'h000) begin
         n_fail++; $display("FAIL flush_idle: got %h expected %h", obs(), 12'h000);
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_reopen: got %b expected 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      n_checks++;
      if (obs() !== beat(3'b010, 5'd0, 1'b1, 1'b1)) begin
         n_fail++; $display("FAIL flush_pending: got %h expected %h", obs(), beat(3'b010, 5'd0, 1'b1, 1'b1));
      end
      tick();
      n_checks++;
      if (obs() !== 12'h000) begin
         n_fail++; $display("FAIL flush_after: got %h expected %h", obs(), 12'h000);
      end
   endtask

   task automatic test_reset_mid_op();
      bus.aluop     = 3'b000;
      bus.funct     = 4'b1011;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (20) tick();
      n_checks++;
      if (obs() !== beat(3'b011, 5'd20, 1'b0, 1'b0)) begin
         n_fail++; $display("FAIL rst_reach20: got %h expected %h", obs(), beat(3'b011, 5'd20, 1'b0, 1'b0));
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs() !== 12'h000) begin
         n_fail++; $display("FAIL rst_async: got %h expected %h", obs(), 12'h000);
      end
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready);
      end
      tick(); tick();
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_release_ready: got %b expected 1", bus.in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (obs() !== 12'h000) begin
            n_fail++; $display("FAIL rst_no_stray%0d: got %h expected %h", i, obs(), 12'h000);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_iterative();
      test_backpressure();
      test_flush();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
